// File: rtl/sap_pkg.sv
// Shared SAP constants and the program-loader state encoding.
// SAP_LOADER_CHECKSUM_EN adds the CHECK state used by the loader's checksum option.
package sap_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_WRITE     = 3'd2,
`ifdef SAP_LOADER_CHECKSUM_EN
        ST_CHECK     = 3'd3,
`endif
        ST_DONE      = 3'd4
    } loader_state_e;

endpackage

// File: rtl/sap_mem_loader_if.sv
// Byte-stream input and memory write bus of the SAP program loader.
// The master modport is the loader; the slave modport is the byte source plus memory.
interface sap_mem_loader_if;
    import sap_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_enable;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_data_oe;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_enable, mem_we, mem_address, mem_data, mem_data_oe
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_enable, mem_we, mem_address, mem_data, mem_data_oe
    );

endinterface

// File: rtl/sap_mem_loader.sv
// Loads DEPTH bytes from a valid/ready stream into SAP memory addresses 0..DEPTH-1.
// Define SAP_LOADER_CHECKSUM_EN to accept a trailing checksum byte and flag mismatches on err.
//
//  state        | meaning
//  -------------+------------------------------------------------------------
//  ST_IDLE      | waiting for start, bus released
//  ST_WAIT_BYTE | in_ready=1, waiting for the next byte
//  ST_WRITE     | one-cycle memory write of the latched byte at the counter
//  ST_CHECK     | in_ready=1, waiting for the checksum byte (option only)
//  ST_DONE      | session complete, bus released, waiting for start
module sap_mem_loader
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    sap_mem_loader_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q;
    loader_state_e     state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              start_session;

    assign start_session = start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_session) begin
                addr_q <= '0;
            end else if (state_q == ST_WRITE && addr_q != LAST_ADDR) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == ST_WAIT_BYTE && bus.in_valid) begin
                data_q <= bus.in_data;
            end
        end
    end

`ifdef SAP_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] chk_total;
    logic              err_q;

    // Wraps naturally at DATA_W bits, giving the mod-256 sum.
    assign chk_total = sum_q + bus.in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (start_session) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            sum_q <= sum_q + data_q;
        end else if (state_q == ST_CHECK && bus.in_valid) begin
            err_q <= (chk_total != '0);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        bus.in_ready    = 1'b0;
        bus.mem_enable  = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_data_oe = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy            = 1'b1;
                bus.mem_enable  = 1'b1;
                bus.mem_we      = 1'b1;
                bus.mem_data_oe = 1'b1;
                bus.mem_address = addr_q;
                bus.mem_data    = data_q;
                if (addr_q == LAST_ADDR) begin
`ifdef SAP_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_WAIT_BYTE;
                end
            end
`ifdef SAP_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                if (start) state_d = ST_WAIT_BYTE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sap_mem_loader.sv
// Self-checking bench for sap_mem_loader with a behavioural memory and timing model.
// Covers both builds; the checksum scenarios are compiled when SAP_LOADER_CHECKSUM_EN is defined.
module tb_sap_mem_loader;
    import sap_pkg::*;

`ifdef SAP_LOADER_CHECKSUM_EN
    localparam int  N_BYTES = DEPTH + 1;
    localparam bit  CHK_ON  = 1'b1;
`else
    localparam int  N_BYTES = DEPTH;
    localparam bit  CHK_ON  = 1'b0;
`endif
    localparam int  MAX_CYC = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    sap_mem_loader_if bus();

    sap_mem_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0]        tb_mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] wr_log [$];
    logic [DATA_W-1:0]        src    [DEPTH+1];
    bit                       valid_hist [MAX_CYC];

    // Behavioural memory: captures a write on the edge that ends the strobe.
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_we) begin
            tb_mem[bus.mem_address] = bus.mem_data;
            wr_log.push_back({bus.mem_address, bus.mem_data});
        end
    end

    // Cycle (counted from the start edge) at which done should first be seen, derived
    // from the offered valid pattern: each data byte costs handshake + write, checksum costs one.
    function automatic int exp_done_cycle();
        int c = 0;
        for (int k = 0; k < N_BYTES; k++) begin
            while (c < MAX_CYC && !valid_hist[c]) c++;
            c += (k < DEPTH) ? 2 : 1;
        end
        return c;
    endfunction

    // mode 0: valid held high, 1: valid toggles every 3 cycles, 2: random valid
    task automatic run_load(input int mode, input int mid_start, output int cyc);
        int   idx = 0;
        logic v;
        logic r;
        for (int i = 0; i < MAX_CYC; i++) valid_hist[i] = 1'b0;
        wr_log.delete();
        @(negedge clk);
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < MAX_CYC) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc / 3) % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx >= N_BYTES) v = 1'b0;
            valid_hist[cyc] = v;
            bus.in_valid = v;
            bus.in_data  = v ? src[idx] : DATA_W'($urandom);
            start        = (cyc == mid_start);
            r            = bus.in_ready;
            @(posedge clk);
            if (v && r) idx++;
            cyc++;
            @(negedge clk);
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.in_ready, bus.mem_enable, bus.mem_we, bus.mem_address, bus.mem_data,
             bus.mem_data_oe, busy, done, err} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got in_ready=%b en=%b we=%b addr=%h data=%h oe=%b busy=%b done=%b err=%b, want all 0",
                     bus.in_ready, bus.mem_enable, bus.mem_we, bus.mem_address, bus.mem_data,
                     bus.mem_data_oe, busy, done, err);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.in_ready, busy, done, bus.mem_we} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_outputs: got in_ready=%b busy=%b done=%b we=%b, want 0000",
                     bus.in_ready, busy, done, bus.mem_we);
        end
    endtask

    task automatic test_streaming();
        int                modes [5] = '{0, 1, 0, 2, 1};
        int                mids  [5] = '{-1, -1, 7, -1, 12};
        int                cyc;
        int                exp_cyc;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] total;
        logic              exp_err;
        for (int s = 0; s < 5; s++) begin
            sum = '0;
            for (int i = 0; i < DEPTH; i++) begin
                src[i] = (s == 0) ? DATA_W'(16 + i) : DATA_W'($urandom);
                sum    = sum + src[i];
            end
            src[DEPTH] = (s == 0) ? (~sum + 8'd1) : DATA_W'($urandom);
            total      = sum + src[DEPTH];
            exp_err    = CHK_ON && (total != '0);
            run_load(modes[s], mids[s], cyc);
            exp_cyc = exp_done_cycle();
            if (s == 0) exp_cyc = CHK_ON ? 2 * DEPTH + 1 : 2 * DEPTH;

            n_vec++;
            if (cyc !== exp_cyc) begin
                n_err++;
                $display("FAIL scn%0d_done_cycle: got %0d want %0d", s, cyc, exp_cyc);
            end
            n_vec++;
            if ({done, busy, bus.in_ready, bus.mem_we, bus.mem_data_oe} !== 5'b10000) begin
                n_err++;
                $display("FAIL scn%0d_final_flags: got done=%b busy=%b in_ready=%b we=%b oe=%b want 1 0 0 0 0",
                         s, done, busy, bus.in_ready, bus.mem_we, bus.mem_data_oe);
            end
            n_vec++;
            if (err !== exp_err) begin
                n_err++;
                $display("FAIL scn%0d_err: got %b want %b", s, err, exp_err);
            end
            n_vec++;
            if (wr_log.size() !== DEPTH) begin
                n_err++;
                $display("FAIL scn%0d_write_count: got %0d want %0d", s, wr_log.size(), DEPTH);
            end
            for (int i = 0; i < DEPTH && i < wr_log.size(); i++) begin
                n_vec++;
                if (wr_log[i] !== {ADDR_W'(i), src[i]}) begin
                    n_err++;
                    $display("FAIL scn%0d_write%0d: got addr/data %h want %h",
                             s, i, wr_log[i], {ADDR_W'(i), src[i]});
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_vec++;
                if (tb_mem[i] !== src[i]) begin
                    n_err++;
                    $display("FAIL scn%0d_mem%0d: got %h want %h", s, i, tb_mem[i], src[i]);
                end
            end
        end
    endtask

`ifdef SAP_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [DATA_W-1:0] chk     [2] = '{8'h78, 8'h77};
        logic              exp_err [2] = '{1'b0, 1'b1};
        int                cyc;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < DEPTH; i++) src[i] = DATA_W'(i + 1);
            src[DEPTH] = chk[t];
            run_load(0, -1, cyc);
            n_vec++;
            if (err !== exp_err[t]) begin
                n_err++;
                $display("FAIL chk%0d_err: got %b want %b", t, err, exp_err[t]);
            end
            n_vec++;
            if (done !== 1'b1 || cyc !== 2 * DEPTH + 1) begin
                n_err++;
                $display("FAIL chk%0d_done: got done=%b cycle=%0d want 1 at %0d", t, done, cyc, 2 * DEPTH + 1);
            end
            n_vec++;
            if (wr_log.size() !== DEPTH) begin
                n_err++;
                $display("FAIL chk%0d_write_count: got %0d want %0d", t, wr_log.size(), DEPTH);
            end
        end
    endtask
`endif

    task automatic test_restart();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_pre_done: got %b want 1", done);
        end
        @(negedge clk);
        start        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({done, err, busy, bus.in_ready} !== 4'b0011) begin
            n_err++;
            $display("FAIL restart_flags: got done=%b err=%b busy=%b in_ready=%b want 0 0 1 1",
                     done, err, busy, bus.in_ready);
        end
        wr_log.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if ({bus.mem_enable, bus.mem_we, bus.mem_data_oe, bus.mem_address, bus.mem_data} !== {3'b111, 4'h0, 8'h5A}) begin
            n_err++;
            $display("FAIL restart_strobe: got en=%b we=%b oe=%b addr=%h data=%h want 1 1 1 0 5a",
                     bus.mem_enable, bus.mem_we, bus.mem_data_oe, bus.mem_address, bus.mem_data);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (wr_log.size() !== 1 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL restart_after_write: got writes=%0d in_ready=%b want 1 1", wr_log.size(), bus.in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] snap [DEPTH];
        int   idx = 0;
        logic r;
        for (int i = 0; i < DEPTH; i++) begin
            snap[i] = tb_mem[i];
            src[i]  = DATA_W'($urandom);
        end
        wr_log.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && wr_log.size() < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src[idx];
            r            = bus.in_ready;
            @(posedge clk);
            if (r) idx++;
            @(negedge clk);
        end
        n_vec++;
        if (wr_log.size() !== 5) begin
            n_err++;
            $display("FAIL midrst_pre_writes: got %0d want 5", wr_log.size());
        end
        bus.in_data = src[idx];
        rst_n       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.in_ready, bus.mem_enable, bus.mem_we, bus.mem_address, bus.mem_data,
             bus.mem_data_oe, busy, done, err} !== 19'h0) begin
            n_err++;
            $display("FAIL midrst_outputs: got in_ready=%b en=%b we=%b addr=%h data=%h oe=%b busy=%b done=%b err=%b, want all 0",
                     bus.in_ready, bus.mem_enable, bus.mem_we, bus.mem_address, bus.mem_data,
                     bus.mem_data_oe, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if (wr_log.size() !== 5 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_post_writes: got writes=%0d busy=%b want 5 0", wr_log.size(), busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (tb_mem[i] !== ((i < 5) ? src[i] : snap[i])) begin
                n_err++;
                $display("FAIL midrst_mem%0d: got %h want %h", i, tb_mem[i], (i < 5) ? src[i] : snap[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_streaming();
`ifdef SAP_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
